// File: rtl/core_pkg.sv
// Shared constants and encodings for the RV64 core pipeline stages.
package core_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef enum logic {
        WB_SEL_ALU = 1'b0,
        WB_SEL_MEM = 1'b1
    } wb_sel_e;

endpackage

// File: rtl/writeback_if.sv
// Memory-to-writeback bundle plus the decode read ports and the stage status outputs.
interface writeback_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
);
    import core_pkg::*;

    logic                  Valid;
    logic [XLEN-1:0]       ReadData;
    logic [XLEN-1:0]       ALUResult;
    logic [REG_ADDR_W-1:0] Rd;
    logic                  BranchTaken;
    logic                  MemtoReg;
    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] Rs1;
    logic [REG_ADDR_W-1:0] Rs2;
    logic [XLEN-1:0]       ReadData1;
    logic [XLEN-1:0]       ReadData2;
    logic [XLEN-1:0]       WBData;
    logic [REG_ADDR_W-1:0] WBRd;
    logic                  WBWrite;
    logic [CNT_W-1:0]      InstRet;
    logic [31:0]           BranchCount;

    modport master (
        output Valid, ReadData, ALUResult, Rd, BranchTaken, MemtoReg, RegWrite, Rs1, Rs2,
        input  ReadData1, ReadData2, WBData, WBRd, WBWrite, InstRet, BranchCount
    );

    modport slave (
        input  Valid, ReadData, ALUResult, Rd, BranchTaken, MemtoReg, RegWrite, Rs1, Rs2,
        output ReadData1, ReadData2, WBData, WBRd, WBWrite, InstRet, BranchCount
    );

endinterface

// File: rtl/writeback_regfile.sv
// Integer register file: one write port, two asynchronous read ports, x0 reads as zero.
module regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREGS];

    // Storage: cleared on reset, x0 never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/writeback.sv
// Writeback stage: latches one retiring instruction, commits it to the register
// file on the following edge, bypasses it to the decode read ports, and counts
// retired instructions and taken branches.
//
//  state | meaning
//  EMPTY | no instruction held in the stage
//  FULL  | stage holds an instruction that commits on the next edge
module writeback #(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input  logic       clk,
    input  logic       reset,
    writeback_if.slave bus
);
    import core_pkg::*;

    localparam int AW = $clog2(NREGS);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_e;

    stage_e           state_q, state_d;
    logic [XLEN-1:0]  wb_data_q;
    logic [AW-1:0]    wb_rd_q;
    logic             wb_we_q;
    logic             wb_br_q;
    logic [CNT_W-1:0] inst_ret_q;
    logic [31:0]      branch_cnt_q;
    logic [XLEN-1:0]  sel_data;
    logic             we_eff;
    logic             commit;
    logic [XLEN-1:0]  rf_rd1, rf_rd2;

    // Stage occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Next occupancy and commit strobe.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            EMPTY: if (bus.Valid) state_d = FULL;
            FULL: begin
                commit = wb_we_q;
                if (!bus.Valid) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Result select; an explicit if keeps an unknown ReadData out of the ALU path.
    always_comb begin
        sel_data = bus.ALUResult;
        if (bus.MemtoReg == 1'(WB_SEL_MEM)) sel_data = bus.ReadData;
    end

    assign we_eff = bus.RegWrite && (bus.Rd != X0);

    // Stage payload; data and destination hold while idle, write strobe drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_br_q   <= 1'b0;
        end else if (bus.Valid) begin
            wb_data_q <= sel_data;
            wb_rd_q   <= bus.Rd;
            wb_we_q   <= we_eff;
            wb_br_q   <= bus.BranchTaken;
        end else begin
            wb_we_q   <= 1'b0;
            wb_br_q   <= 1'b0;
        end
    end

    // Retire counters, free-running with wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_ret_q   <= '0;
            branch_cnt_q <= '0;
        end else if (state_q == FULL) begin
            inst_ret_q <= inst_ret_q + 1'b1;
            if (wb_br_q) branch_cnt_q <= branch_cnt_q + 1'b1;
        end
    end

    regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (commit),
        .waddr  (wb_rd_q),
        .wdata  (wb_data_q),
        .raddr1 (bus.Rs1),
        .raddr2 (bus.Rs2),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    // Write-first bypass of the committing value onto both read ports.
    always_comb begin
        bus.ReadData1 = rf_rd1;
        bus.ReadData2 = rf_rd2;
        if (wb_we_q && (wb_rd_q == bus.Rs1) && (bus.Rs1 != X0)) bus.ReadData1 = wb_data_q;
        if (wb_we_q && (wb_rd_q == bus.Rs2) && (bus.Rs2 != X0)) bus.ReadData2 = wb_data_q;
    end

    assign bus.WBData      = wb_data_q;
    assign bus.WBRd        = wb_rd_q;
    assign bus.WBWrite     = wb_we_q;
    assign bus.InstRet     = inst_ret_q;
    assign bus.BranchCount = branch_cnt_q;

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for the writeback stage.
module tb_writeback;
    import core_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    writeback_if #(.XLEN(64), .CNT_W(64)) bus ();

    writeback #(.XLEN(64), .NREGS(32), .CNT_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        wr;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] mregs [32];
    logic        mst_v, mst_we, mst_br;
    logic [63:0] mst_d;
    logic [4:0]  mst_rd;
    logic [63:0] m_instret;
    logic [31:0] m_brcnt;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mst_v = 0; mst_we = 0; mst_br = 0; mst_d = '0; mst_rd = '0;
        m_instret = '0; m_brcnt = '0;
        sbq.delete();
    endtask

    function automatic logic [63:0] exp_read(input logic [4:0] rs);
        if (rs == 5'd0) return 64'd0;
        if (mst_we && (mst_rd == rs)) return mst_d;
        return mregs[rs];
    endfunction

    task automatic drive(input logic v, input logic [63:0] rdata, input logic [63:0] alu,
                         input logic [4:0] rd, input logic br, input logic m2r, input logic rw,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        bus.Valid = v; bus.ReadData = rdata; bus.ALUResult = alu; bus.Rd = rd;
        bus.BranchTaken = br; bus.MemtoReg = m2r; bus.RegWrite = rw;
        bus.Rs1 = rs1; bus.Rs2 = rs2;
    endtask

    // One clock: drive, push expectation, clock, update model, compare.
    task automatic cycle(input logic v, input logic [63:0] rdata, input logic [63:0] alu,
                         input logic [4:0] rd, input logic br, input logic m2r, input logic rw,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        exp_t e;
        drive(v, rdata, alu, rd, br, m2r, rw, rs1, rs2);
        if (v) begin
            e.data = m2r ? rdata : alu;
            e.rd   = rd;
            e.wr   = rw && (rd != 5'd0);
            sbq.push_back(e);
        end
        @(posedge clk);
        if (mst_v) begin
            if (mst_we) mregs[mst_rd] = mst_d;
            m_instret = m_instret + 1;
            if (mst_br) m_brcnt = m_brcnt + 1;
        end
        mst_v = v;
        if (v) begin
            mst_we = rw && (rd != 5'd0);
            mst_d  = m2r ? rdata : alu;
            mst_rd = rd;
            mst_br = br;
        end else begin
            mst_we = 0;
            mst_br = 0;
        end
        #1;
        if (v) begin
            if (sbq.size() == 0) begin
                check("sb_empty", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                check("wbdata", bus.WBData, e.data);
                check("wbrd", 64'(bus.WBRd), 64'(e.rd));
                check("wbwrite", 64'(bus.WBWrite), 64'(e.wr));
            end
        end else begin
            check("wbwrite_idle", 64'(bus.WBWrite), 64'd0);
            check("wbdata_hold", bus.WBData, mst_d);
        end
        check("instret", bus.InstRet, m_instret);
        check("brcount", 64'(bus.BranchCount), 64'(m_brcnt));
        check("rd1", bus.ReadData1, exp_read(rs1));
        check("rd2", bus.ReadData2, exp_read(rs2));
    endtask

    initial begin
        model_clear();
        drive(0, '0, '0, 0, 0, 0, 0, 5, 0);
        reset = 1'b1;
        #1;
        check("rst_wbwrite", 64'(bus.WBWrite), 64'd0);
        check("rst_wbdata", bus.WBData, 64'd0);
        check("rst_wbrd", 64'(bus.WBRd), 64'd0);
        check("rst_instret", bus.InstRet, 64'd0);
        check("rst_brcnt", 64'(bus.BranchCount), 64'd0);
        check("rst_rd1", bus.ReadData1, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: ALU result to x5, ReadData unknown while MemtoReg=0
        cycle(1, 'x, 64'h1234, 5, 0, 0, 1, 5, 0);
        cycle(0, '0, '0, 0, 0, 0, 0, 5, 5);

        // 2: load data to x13, bypass seen during commit cycle
        cycle(1, 64'hDEADBEEFDEADBEEF, 64'h10, 13, 0, 1, 1, 5, 13);
        cycle(0, '0, '0, 0, 0, 0, 0, 13, 13);

        // 3: write to x0 suppressed
        cycle(1, '0, 64'hFFFF, 0, 0, 0, 1, 0, 0);
        cycle(0, '0, '0, 0, 0, 0, 0, 0, 13);

        // 4: back-to-back, middle is a taken branch without write
        cycle(1, '0, 64'h111, 1, 0, 0, 1, 1, 2);
        cycle(1, '0, 64'h222, 2, 1, 0, 0, 1, 2);
        cycle(1, '0, 64'h333, 3, 0, 0, 1, 2, 3);
        cycle(0, '0, '0, 0, 0, 0, 0, 1, 3);
        cycle(0, '0, '0, 0, 0, 0, 0, 2, 3);

        // 5: commit x7, then reset mid-cycle with a new instruction latched
        cycle(1, '0, 64'hAAAAAAAAAAAAAAAA, 7, 0, 0, 1, 7, 0);
        cycle(0, '0, '0, 0, 0, 0, 0, 7, 7);
        drive(1, '0, 64'h5555, 7, 1, 0, 1, 7, 7);
        @(posedge clk); #2;
        check("pre_rst_wbwrite", 64'(bus.WBWrite), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_wbwrite", 64'(bus.WBWrite), 64'd0);
        check("mid_rst_wbdata", bus.WBData, 64'd0);
        check("mid_rst_wbrd", 64'(bus.WBRd), 64'd0);
        check("mid_rst_instret", bus.InstRet, 64'd0);
        check("mid_rst_brcnt", 64'(bus.BranchCount), 64'd0);
        check("mid_rst_x7", bus.ReadData1, 64'd0);
        model_clear();
        drive(0, '0, '0, 0, 0, 0, 0, 7, 7);
        @(posedge clk); #1;
        reset = 1'b0;
        cycle(0, '0, '0, 0, 0, 0, 0, 7, 7);
        cycle(0, '0, '0, 0, 0, 0, 0, 7, 7);

        // 6: commit x7 then idle for four cycles, both ports on x7
        cycle(1, '0, 64'h0123456789ABCDEF, 7, 0, 0, 1, 7, 7);
        for (int i = 0; i < 4; i++) cycle(0, '0, '0, 0, 0, 0, 0, 7, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
